// File: rtl/enc_lag3_pipe_pkg.sv
// enc_lag3_pipe_pkg: shared constants and FSM encoding for the pitch-lag encoder.
package enc_lag3_pipe_pkg;
  localparam int PIT_MIN = 20;
  localparam int PIT_MAX = 143;
  localparam logic [11:0] T0_MIN_ADDR = 12'hF00;
  localparam logic [11:0] T0_MAX_ADDR = 12'hF01;
  typedef enum logic [2:0] {
    IDLE,
    RD_MIN,
    RD_WAIT,
    COMPUTE,
    WR_MIN,
    WR_MAX,
    DONE
  } state_t;
endpackage

// File: rtl/enc_lag3_scratch_mem.sv
// enc_lag3_scratch_mem: 1R/1W scratch RAM, synchronous write, registered read.
module enc_lag3_scratch_mem #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [DATA_W-1:0] rdData,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
    rdData <= mem[rdAddr];
  end
endmodule

// File: rtl/enc_lag3_pipe.sv
// enc_lag3_pipe: G.729 Enc_lag3 lag-index encoder with its T0_min/T0_max window in scratch memory.
module enc_lag3_pipe #(
  parameter int PIT_MIN = enc_lag3_pipe_pkg::PIT_MIN,
  parameter int PIT_MAX = enc_lag3_pipe_pkg::PIT_MAX,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              Enc_lag3MuxSel,
  input  logic [15:0]       T0,
  input  logic [15:0]       T0_frac,
  input  logic [15:0]       pit_flag,
  input  logic [ADDR_W-1:0] testReadAddr,
  input  logic [ADDR_W-1:0] testWriteAddr,
  input  logic [DATA_W-1:0] testMemOut,
  input  logic              testMemWriteEn,
  output logic              done,
  output logic [15:0]       index,
  output logic [DATA_W-1:0] memIn
);
  import enc_lag3_pipe_pkg::*;

  localparam logic [15:0] pMin = 16'(PIT_MIN);
  localparam logic [15:0] pMax = 16'(PIT_MAX);
  localparam logic [ADDR_W-1:0] minAddr = ADDR_W'(T0_MIN_ADDR);
  localparam logic [ADDR_W-1:0] maxAddr = ADDR_W'(T0_MAX_ADDR);

  state_t state, nextState;
  logic [15:0] t0, t0Frac, tmin, tmax;
  logic pitFirst;
  logic fsmWrEn;
  logic [ADDR_W-1:0] fsmWrAddr, rdAddr, wrAddr;
  logic [DATA_W-1:0] fsmWrData, wrData;
  logic wrEn;
  logic [15:0] idxFirst, idxSecond, winLo, winMin, winHi;
  logic winOver;

  // All lag arithmetic is 16-bit modular, matching the Word16 reference code.
  assign idxFirst  = (t0 <= 16'd85) ? t0 * 16'd3 - 16'd58 + t0Frac : t0 + 16'd112;
  assign idxSecond = (t0 - tmin) * 16'd3 + 16'd2 + t0Frac;
  assign winLo     = t0 - 16'd5;
  assign winMin    = ($signed(winLo) < $signed(pMin)) ? pMin : winLo;
  assign winHi     = winMin + 16'd9;
  assign winOver   = $signed(winHi) > $signed(pMax);

  assign rdAddr = Enc_lag3MuxSel ? testReadAddr : minAddr;
  assign wrAddr = Enc_lag3MuxSel ? testWriteAddr : fsmWrAddr;
  assign wrData = Enc_lag3MuxSel ? testMemOut : fsmWrData;
  assign wrEn   = Enc_lag3MuxSel ? testMemWriteEn : fsmWrEn;

  enc_lag3_scratch_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) scratch (
    .clk    (clk),
    .rdAddr (rdAddr),
    .rdData (memIn),
    .wrEn   (wrEn),
    .wrAddr (wrAddr),
    .wrData (wrData)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= nextState;
  end

  always_comb begin
    nextState = state;
    fsmWrEn   = 1'b0;
    fsmWrAddr = minAddr;
    fsmWrData = DATA_W'(tmin);
    done      = 1'b0;
    case (state)
      IDLE:    nextState = start ? RD_MIN : IDLE;
      RD_MIN:  nextState = RD_WAIT;
      RD_WAIT: nextState = COMPUTE;
      COMPUTE: nextState = pitFirst ? WR_MIN : DONE;
      WR_MIN: begin
        fsmWrEn   = 1'b1;
        nextState = WR_MAX;
      end
      WR_MAX: begin
        fsmWrEn   = 1'b1;
        fsmWrAddr = maxAddr;
        fsmWrData = DATA_W'(tmax);
        nextState = DONE;
      end
      DONE: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t0       <= '0;
      t0Frac   <= '0;
      pitFirst <= 1'b0;
      tmin     <= '0;
      tmax     <= '0;
      index    <= '0;
    end else begin
      if (state == IDLE && start) begin
        t0       <= T0;
        t0Frac   <= T0_frac;
        pitFirst <= (pit_flag == 16'd0);
      end
      if (state == RD_WAIT) tmin <= memIn[15:0];
      if (state == COMPUTE) begin
        index <= pitFirst ? idxFirst : idxSecond;
        if (pitFirst) begin
          tmin <= winOver ? pMax - 16'd9 : winMin;
          tmax <= winOver ? pMax : winHi;
        end
      end
    end
  end
endmodule

// File: tb/tb_enc_lag3_pipe.sv
// tb_enc_lag3_pipe: randomized self-checking bench for enc_lag3_pipe against an arithmetic lag model.
module tb_enc_lag3_pipe;
  localparam logic [11:0] MIN_A = 12'hF00;
  localparam logic [11:0] MAX_A = 12'hF01;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, sel = 1'b0, we = 1'b0;
  logic [15:0] t0 = '0, frac = '0, pf = '0;
  logic [11:0] ra = '0, wa = '0;
  logic [31:0] wd = '0;
  logic done;
  logic [15:0] index;
  logic [31:0] memIn;
  int errors = 0, checks = 0;
  int modelMin = 0, modelMax = 0;

  always #5 clk = ~clk;

  enc_lag3_pipe dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .Enc_lag3MuxSel (sel),
    .T0             (t0),
    .T0_frac        (frac),
    .pit_flag       (pf),
    .testReadAddr   (ra),
    .testWriteAddr  (wa),
    .testMemOut     (wd),
    .testMemWriteEn (we),
    .done           (done),
    .index          (index),
    .memIn          (memIn)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic memWrite(input logic [11:0] a, input logic [31:0] d);
    sel = 1'b1; wa = a; wd = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0; sel = 1'b0;
    if (a == MIN_A) modelMin = int'(d[15:0]);
    if (a == MAX_A) modelMax = int'(d[15:0]);
  endtask

  task automatic memRead(input logic [11:0] a, output logic [31:0] d);
    sel = 1'b1; ra = a;
    @(negedge clk);
    d = memIn; sel = 1'b0;
  endtask

  task automatic checkWindow(input string tag);
    logic [31:0] d;
    memRead(MIN_A, d);
    check({tag, "_min"}, d, 32'(modelMin));
    memRead(MAX_A, d);
    check({tag, "_max"}, d, 32'(modelMax));
  endtask

  task automatic runOp(input string tag, input int t0v, input int fracv, input int pfv,
                       input int hold, input bit junkWr);
    int expIdx, expLat, n, lo, hi, extra;
    if (pfv == 0) begin
      expIdx = (t0v <= 85) ? t0v * 3 - 58 + fracv : t0v + 112;
      lo = (t0v - 5 < 20) ? 20 : t0v - 5;
      hi = lo + 9;
      if (hi > 143) begin hi = 143; lo = 134; end
      expLat = 6;
    end else begin
      expIdx = 3 * (t0v - modelMin) + 2 + fracv;
      lo = modelMin; hi = modelMax;
      expLat = 4;
    end
    t0 = 16'(t0v); frac = 16'(fracv); pf = 16'(pfv); start = 1'b1;
    if (junkWr) begin wa = MIN_A; wd = 32'hDEADBEEF; we = 1'b1; end
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (n >= hold) start = 1'b0;
      if (done) break;
    end
    we = 1'b0;
    check({tag, "_lat"}, 32'(n), 32'(expLat));
    check({tag, "_idx"}, 32'(index), 32'(expIdx & 32'hFFFF));
    modelMin = lo; modelMax = hi;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) extra++;
    end
    check({tag, "_extra"}, 32'(extra), 32'd0);
    checkWindow(tag);
  endtask

  initial begin
    int extra, lo, t0v, fracv, pfv;
    repeat (3) @(negedge clk);
    check("reset_done", 32'(done), 32'd0);
    check("reset_idx", 32'(index), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    memWrite(MIN_A, 32'd0);
    memWrite(MAX_A, 32'd0);
    runOp("t50", 50, 1, 0, 1, 1'b0);
    check("t50_idx_const", 32'(index), 32'h5D);
    runOp("t100", 100, 0, 0, 1, 1'b0);
    runOp("t85", 85, 1, 0, 1, 1'b0);
    runOp("t86", 86, 0, 0, 1, 1'b0);
    runOp("t22", 22, -1, 0, 1, 1'b0);
    runOp("t140", 140, 0, 0, 1, 1'b0);

    memWrite(MIN_A, 32'd45);
    memWrite(MAX_A, 32'd54);
    runOp("pf1", 48, -1, 1, 1, 1'b0);
    check("pf1_idx_const", 32'(index), 32'd10);

    t0 = 16'd60; frac = 16'd0; pf = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_idx", 32'(index), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("midrst_nodone", 32'(extra), 32'd0);
    checkWindow("midrst");
    runOp("after_rst", 77, 1, 0, 1, 1'b0);

    runOp("held", 120, -1, 0, 2, 1'b1);
    runOp("held_pf1", 118, 1, 5, 2, 1'b1);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        lo = int'($urandom_range(20, 134));
        memWrite(MIN_A, 32'(lo));
        memWrite(MAX_A, 32'(lo + 9));
      end
      t0v = int'($urandom_range(20, 143));
      fracv = int'($urandom_range(0, 2)) - 1;
      pfv = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 65535)) : 0;
      runOp($sformatf("rnd%0d", i), t0v, fracv, pfv, 1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
